bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_converter_pkg.sv | 7 +
 rtl/bcd_add3.sv | 7 +
 rtl/bcd_converter.sv | 68 ++++++
 tb/tb_bcd_converter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bcd_converter_pkg.sv
// bcd_converter_pkg: shared state encoding and conversion constants for the BCD converter.
package bcd_converter_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  localparam int ITERATIONS = 16;
  localparam int NUM_DIGITS = 5;
  localparam logic [15:0] SAT_VALUE = 16'h9999;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bcd_converter.sv
// bcd_converter: 16-bit binary to five-digit BCD, one double-dabble step per clock.
module bcd_converter
  import bcd_converter_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] binary,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [3:0]  ten_thousands,
  output logic        overflow
);
  state_t      r_state, w_next;
  logic [15:0] r_sr;
  logic [19:0] r_scr, w_adj, w_scr_nx;
  logic [3:0]  r_cnt;
  logic        w_last, w_ovf;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (.i_digit(r_scr[4*d +: 4]), .o_digit(w_adj[4*d +: 4]));
  end

  assign w_scr_nx = {w_adj[18:0], r_sr[15]};
  assign w_last   = r_cnt == 4'(ITERATIONS - 1);
  assign w_ovf    = w_scr_nx[19:16] != 4'd0;

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb
    w_next = (r_state == IDLE)    ? (start  ? CONVERT : IDLE) :
             (r_state == CONVERT) ? (w_last ? DONE    : CONVERT) : IDLE;

  // Outputs only change on the final iteration, so partial results never leak out.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_sr          <= '0;
      r_scr         <= '0;
      r_cnt         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bcd           <= '0;
      ten_thousands <= '0;
      overflow      <= 1'b0;
    end else begin
      busy <= w_next != IDLE;
      done <= w_next == DONE;
      if (r_state == IDLE && start) begin
        r_sr  <= binary;
        r_scr <= '0;
        r_cnt <= '0;
      end else if (r_state == CONVERT) begin
        r_sr  <= r_sr << 1;
        r_scr <= w_scr_nx;
        r_cnt <= r_cnt + 4'd1;
        if (w_last) begin
          ten_thousands <= w_scr_nx[19:16];
          overflow      <= w_ovf;
          bcd           <= (SATURATE && w_ovf) ? SAT_VALUE : w_scr_nx[15:0];
        end
      end
    end
endmodule

// File: tb/tb_bcd_converter.sv
// tb_bcd_converter: checks saturating and wrapping converters against an arithmetic decimal model.
module tb_bcd_converter;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] binary = '0;
  logic        busy1, done1, ovf1, busy0, done0, ovf0;
  logic [15:0] bcd1, bcd0;
  logic [3:0]  tt1, tt0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bcd_converter #(.SATURATE(1'b1)) dut1 (.clock(clk), .reset(rst), .start(start), .binary(binary),
    .busy(busy1), .done(done1), .bcd(bcd1), .ten_thousands(tt1), .overflow(ovf1));
  bcd_converter #(.SATURATE(1'b0)) dut0 (.clock(clk), .reset(rst), .start(start), .binary(binary),
    .busy(busy0), .done(done0), .bcd(bcd0), .ten_thousands(tt0), .overflow(ovf0));

  function automatic logic [15:0] exp_bcd(input int v, input bit sat);
    int lo;
    lo = v % 10000;
    if (sat && v > 9999) return 16'h9999;
    return {4'(lo / 1000), 4'(lo / 100 % 10), 4'(lo / 10 % 10), 4'(lo % 10)};
  endfunction

  task automatic run_conv(input int v, input string name);
    int lat;
    @(negedge clk); start = 1'b1; binary = 16'(v);
    @(posedge clk);
    @(negedge clk); start = 1'b0; binary = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done1 && lat == 0) lat = i;
      if (lat != 0) break;
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL %s latency: got %0d want 16", name, lat); end
    checks++;
    if ({done0, busy1, busy0} !== 3'b111) begin errors++; $display("FAIL %s done0/busy: got %b want 111", name, {done0, busy1, busy0}); end
    checks++;
    if (bcd1 !== exp_bcd(v, 1) || bcd0 !== exp_bcd(v, 0)) begin
      errors++; $display("FAIL %s bcd: got %h/%h want %h/%h", name, bcd1, bcd0, exp_bcd(v, 1), exp_bcd(v, 0));
    end
    checks++;
    if (tt1 !== 4'(v / 10000) || tt0 !== 4'(v / 10000) || ovf1 !== (v > 9999) || ovf0 !== (v > 9999)) begin
      errors++; $display("FAIL %s tt/ovf: got %0d,%b/%0d,%b want %0d,%b", name, tt1, ovf1, tt0, ovf0, v / 10000, v > 9999);
    end
    @(posedge clk); #1;
    checks++;
    if ({done1, busy1, done0, busy0} !== 4'b0) begin errors++; $display("FAIL %s after done: got %b want 0000", name, {done1, busy1, done0, busy0}); end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy1, done1, bcd1, tt1, ovf1, busy0, done0, bcd0, tt0, ovf0} !== '0) begin
      errors++; $display("FAIL reset: got bcd %h/%h tt %0d/%0d busy %b done %b", bcd1, bcd0, tt1, tt0, busy1, done1);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    run_conv(0, "zero");
    run_conv(1234, "1234");
    run_conv(9999, "9999");
    run_conv(10000, "10000");
    run_conv(65535, "65535");
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) run_conv(int'($urandom_range(0, 65535)), "random");
  endtask

  task automatic test_back_to_back;
    int q[$];
    int v;
    @(negedge clk); start = 1'b1;
    for (int c = 0; c <= 3 * 18 + 16; c++) begin
      binary = 16'($urandom);
      if (c % 18 == 0 && c < 3 * 18 + 16) q.push_back(int'(binary));
      @(posedge clk); #1;
      checks++;
      if (done1 !== (c >= 16 && (c - 16) % 18 == 0)) begin
        errors++; $display("FAIL b2b done at cycle %0d: got %b want %b", c, done1, !done1);
      end
      if (done1 && q.size() > 0) begin
        v = q.pop_front();
        checks++;
        if (bcd1 !== exp_bcd(v, 1) || bcd0 !== exp_bcd(v, 0) || tt1 !== 4'(v / 10000)) begin
          errors++; $display("FAIL b2b result for %0d: got %h/%h tt %0d want %h/%h tt %0d", v, bcd1, bcd0, tt1, exp_bcd(v, 1), exp_bcd(v, 0), v / 10000);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit seen;
    run_conv(65535, "pre-abort");
    @(negedge clk); start = 1'b1; binary = 16'd1234;
    @(negedge clk); start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, bcd1, tt1, ovf1, busy0, done0, bcd0, tt0, ovf0} !== '0) begin
      errors++; $display("FAIL mid reset: got bcd %h/%h tt %0d ovf %b busy %b", bcd1, bcd0, tt1, ovf1, busy1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (24) begin @(posedge clk); #1; seen |= done1 | done0 | busy1; end
    checks++;
    if (seen) begin errors++; $display("FAIL abort activity: got done/busy 1 want 0"); end
    run_conv(42, "post-abort 42");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
